// File: rtl/bin_to_7seg_if.sv
// bin_to_7seg_if: value/segment bundle between a binary value source and the
// four-digit seven-segment converter.
//   IN_i            12-bit unsigned value to display (0-4095)
//   OUTa_o..OUTg_o  segments a-g, one bit per digit
//                   (bit 0 units, 1 tens, 2 hundreds, 3 thousands), active-high
// master: value source / display consumer side; slave: converter side.
interface bin_to_7seg_if;
   localparam int unsigned IN_W  = 12;
   localparam int unsigned DIG_N = 4;

   logic [IN_W-1:0]  IN_i;
   logic [DIG_N-1:0] OUTa_o;
   logic [DIG_N-1:0] OUTb_o;
   logic [DIG_N-1:0] OUTc_o;
   logic [DIG_N-1:0] OUTd_o;
   logic [DIG_N-1:0] OUTe_o;
   logic [DIG_N-1:0] OUTf_o;
   logic [DIG_N-1:0] OUTg_o;

   modport master (
      output IN_i,
      input  OUTa_o, OUTb_o, OUTc_o, OUTd_o, OUTe_o, OUTf_o, OUTg_o
   );

   modport slave (
      input  IN_i,
      output OUTa_o, OUTb_o, OUTc_o, OUTd_o, OUTe_o, OUTf_o, OUTg_o
   );
endinterface

// File: rtl/bin_to_7seg.sv
// bin_to_7seg: registered 12-bit binary to four-digit seven-segment converter.
// Combinational double-dabble turns IN_i into four BCD digits, each digit is
// decoded to an active-high abcdefg pattern, and all 28 segment bits are
// registered on the rising clock edge (one cycle latency, no leading-zero
// blanking).
//   CLK_i  system clock
//   RST_i  asynchronous active-high reset, blanks every segment output
//   bus    slave side of bin_to_7seg_if (IN_i in, OUTa_o..OUTg_o out)
module bin_to_7seg (
   input  logic          CLK_i,
   input  logic          RST_i,
   bin_to_7seg_if.slave  bus
);
   localparam int unsigned IN_W  = 12;
   localparam int unsigned DIG_N = 4;
   localparam int unsigned DIG_W = 4;
   localparam int unsigned BCD_W = DIG_N * DIG_W;
   localparam int unsigned SEG_N = 7;

   // Decode one BCD digit to abcdefg (bit 6 = a ... bit 0 = g); 10-15 stay dark.
   function automatic logic [SEG_N-1:0] seg_of(input logic [DIG_W-1:0] dig);
      logic [SEG_N-1:0] pat;
      case (dig)
         4'd0:    pat = 7'b1111110;
         4'd1:    pat = 7'b0110000;
         4'd2:    pat = 7'b1101101;
         4'd3:    pat = 7'b1111001;
         4'd4:    pat = 7'b0110011;
         4'd5:    pat = 7'b1011011;
         4'd6:    pat = 7'b1011111;
         4'd7:    pat = 7'b1110000;
         4'd8:    pat = 7'b1111111;
         4'd9:    pat = 7'b1111011;
         default: pat = 7'b0000000;
      endcase
      return pat;
   endfunction

   logic [BCD_W-1:0] bcd;

   // Double dabble: before each shift, any digit >= 5 gets +3 so it carries
   // correctly into the next digit after doubling.
   always_comb begin
      bcd = '0;
      for (int i = IN_W - 1; i >= 0; i--) begin
         for (int k = 0; k < DIG_N; k++) begin
            if (bcd[k*DIG_W +: DIG_W] >= 4'd5) begin
               bcd[k*DIG_W +: DIG_W] = bcd[k*DIG_W +: DIG_W] + 4'd3;
            end
         end
         bcd = {bcd[BCD_W-2:0], bus.IN_i[i]};
      end
   end

   logic [DIG_N-1:0] nxt_a, nxt_b, nxt_c, nxt_d, nxt_e, nxt_f, nxt_g;

   // Per-digit decode, regrouped so each segment output carries one bit per digit.
   always_comb begin
      logic [SEG_N-1:0] pat;
      pat   = '0;
      nxt_a = '0;
      nxt_b = '0;
      nxt_c = '0;
      nxt_d = '0;
      nxt_e = '0;
      nxt_f = '0;
      nxt_g = '0;
      for (int k = 0; k < DIG_N; k++) begin
         pat      = seg_of(bcd[k*DIG_W +: DIG_W]);
         nxt_a[k] = pat[6];
         nxt_b[k] = pat[5];
         nxt_c[k] = pat[4];
         nxt_d[k] = pat[3];
         nxt_e[k] = pat[2];
         nxt_f[k] = pat[1];
         nxt_g[k] = pat[0];
      end
   end

   // Output register; reset blanks the display and drops any in-flight value.
   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         bus.OUTa_o <= '0;
         bus.OUTb_o <= '0;
         bus.OUTc_o <= '0;
         bus.OUTd_o <= '0;
         bus.OUTe_o <= '0;
         bus.OUTf_o <= '0;
         bus.OUTg_o <= '0;
      end else begin
         bus.OUTa_o <= nxt_a;
         bus.OUTb_o <= nxt_b;
         bus.OUTc_o <= nxt_c;
         bus.OUTd_o <= nxt_d;
         bus.OUTe_o <= nxt_e;
         bus.OUTf_o <= nxt_f;
         bus.OUTg_o <= nxt_g;
      end
   end
endmodule

// File: tb/tb_bin_to_7seg.sv
// tb_bin_to_7seg: scoreboard bench for bin_to_7seg. Stimulus drives IN_i on the
// falling edge and queues the expected 28 segment bits; a monitor pops one
// entry after every rising edge and compares. Expected digits come from
// decimal division, patterns from the segment truth table.
module tb_bin_to_7seg;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   logic [27:0] exp_q[$];

   bin_to_7seg_if bus ();

   bin_to_7seg dut (
      .CLK_i (clk),
      .RST_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: decimal digits by division, pattern by truth table.
   function automatic logic [27:0] model(input int v);
      logic [6:0] tbl [10];
      logic [3:0] a, b, c, d, e, f, g;
      logic [6:0] p;
      int scale;
      int dig;
      tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
      {a, b, c, d, e, f, g} = '0;
      scale = 1;
      for (int k = 0; k < 4; k++) begin
         dig  = (v / scale) % 10;
         p    = tbl[dig];
         a[k] = p[6]; b[k] = p[5]; c[k] = p[4]; d[k] = p[3];
         e[k] = p[2]; f[k] = p[1]; g[k] = p[0];
         scale = scale * 10;
      end
      return {a, b, c, d, e, f, g};
   endfunction

   function automatic logic [27:0] actual();
      return {bus.OUTa_o, bus.OUTb_o, bus.OUTc_o, bus.OUTd_o,
              bus.OUTe_o, bus.OUTf_o, bus.OUTg_o};
   endfunction

   task automatic drive(input int v);
      bus.IN_i = 12'(v);
      exp_q.push_back(model(v));
   endtask

   task automatic check_blank(input string name);
      logic [27:0] act;
      act = actual();
      checks++;
      if (act !== 28'h0) begin
         failures++;
         $display("FAIL %s: got abcdefg=%07h want 0000000", name, act);
      end
   endtask

   // Monitor: each rising edge the DUT presents a new value.
   initial begin
      logic [27:0] exp_v;
      logic [27:0] act;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act   = actual();
            checks++;
            if (act !== exp_v) begin
               failures++;
               $display("FAIL seg_out: got abcdefg=%07h want %07h", act, exp_v);
            end
         end
      end
   end

   initial begin
      int dir [] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 1234, 4095, 9, 10, 99, 100, 999, 1000};
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus.IN_i = 12'd1234;

      // Reset held with a live input: display stays blank.
      @(negedge clk);
      check_blank("reset_hold0");
      @(negedge clk);
      check_blank("reset_hold1");

      // Release; first edge loads 1234.
      rst = 1'b0;
      exp_q.push_back(model(1234));

      foreach (dir[i]) begin
         @(negedge clk);
         drive(dir[i]);
      end

      // Mid-operation reset between edges: in-flight value dropped, blank at once.
      @(negedge clk);
      drive(777);
      #2;
      rst = 1'b1;
      exp_q.delete();
      #1;
      check_blank("reset_async");
      @(posedge clk);
      #1;
      check_blank("reset_edge");
      @(negedge clk);
      bus.IN_i = 12'd1234;
      rst      = 1'b0;
      exp_q.push_back(model(1234));

      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         drive(int'($urandom_range(0, 4095)));
      end

      // Drain: every queued expectation must have been consumed.
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
